// File: rtl/fibonacci_bin_decoder.sv
// Bit-serial Fibonacci-to-binary decoder. It consumes one codeword bit per clock and
// generates the Fibonacci weights on the fly, so any representation, canonical or not, decodes.
module fibonacci_bin_decoder #(
  parameter int FIB_W = 32,
  parameter int BIN_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             begin_f_b,
  input  logic [FIB_W-1:0] input_fib,
  output logic [BIN_W-1:0] output_bin,
  output logic             overflow,
  output logic             non_canonical,
  output logic             busy,
  output logic             convert_done
);

  localparam int IDX_W = $clog2(FIB_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FIB_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [FIB_W-1:0] r_sr;
  logic [ACC_W-1:0] r_acc, r_wa, r_wb;
  logic [IDX_W-1:0] r_idx;
  logic             r_nc;
  logic [BIN_W-1:0] r_bin;
  logic             r_ovf, r_nc_out, r_done;
  logic             w_busy, w_nc_in, w_sat;

  // Adjacent ones anywhere in the word mark a non-Zeckendorf form.
  assign w_nc_in = |(input_fib & (input_fib >> 1));
  assign w_sat   = |r_acc[ACC_W-1:BIN_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (begin_f_b) w_next = S_RUN;
      S_RUN:  if (r_idx == LAST_IDX) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr     <= '0;
      r_acc    <= '0;
      r_wa     <= '0;
      r_wb     <= '0;
      r_idx    <= '0;
      r_nc     <= 1'b0;
      r_bin    <= '0;
      r_ovf    <= 1'b0;
      r_nc_out <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (begin_f_b) begin
          r_sr  <= input_fib;
          r_acc <= '0;
          r_wa  <= ACC_W'(1);
          r_wb  <= ACC_W'(2);
          r_idx <= '0;
          r_nc  <= w_nc_in;
        end
        // wa always carries the weight of the bit currently at sr[0].
        S_RUN: begin
          if (r_sr[0]) r_acc <= r_acc + r_wa;
          r_sr  <= r_sr >> 1;
          r_wa  <= r_wb;
          r_wb  <= r_wa + r_wb;
          r_idx <= r_idx + 1'b1;
        end
        S_DONE: begin
          r_bin    <= w_sat ? '1 : r_acc[BIN_W-1:0];
          r_ovf    <= w_sat;
          r_nc_out <= r_nc;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign output_bin    = r_bin;
  assign overflow      = r_ovf;
  assign non_canonical = r_nc_out;
  assign busy          = w_busy;
  assign convert_done  = r_done;

endmodule

// File: tb/tb_fibonacci_bin_decoder.sv
// Randomised and directed bench for fibonacci_bin_decoder against an arithmetic weight-sum model.
module tb_fibonacci_bin_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        begin_f_b = 1'b0;
  logic [31:0] input_fib = '0;
  logic [15:0] output_bin;
  logic        overflow, non_canonical, busy, convert_done;

  int vectors = 0;
  int miscompares = 0;
  longint w [0:31];

  fibonacci_bin_decoder dut (
    .clk(clk), .rst(rst), .begin_f_b(begin_f_b), .input_fib(input_fib),
    .output_bin(output_bin), .overflow(overflow), .non_canonical(non_canonical),
    .busy(busy), .convert_done(convert_done)
  );

  always #5 clk = ~clk;

  function automatic longint model_sum(input logic [31:0] cw);
    longint s = 0;
    for (int i = 0; i < 32; i++) if (cw[i]) s += w[i];
    return s;
  endfunction

  function automatic logic [15:0] model_bin(input logic [31:0] cw);
    longint s = model_sum(cw);
    return (s > 65535) ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic model_nc(input logic [31:0] cw);
    for (int i = 0; i < 31; i++) if (cw[i] && cw[i+1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
  endtask

  // Starts one conversion and returns edges from the start edge to the done pulse (-1 if none).
  task automatic run_conv(input logic [31:0] cw, output int lat);
    wait_idle();
    @(negedge clk);
    begin_f_b = 1'b1;
    input_fib = cw;
    @(negedge clk);
    begin_f_b = 1'b0;
    input_fib = $urandom;
    lat = -1;
    for (int t = 1; t <= 60; t++) begin
      @(negedge clk);
      if (convert_done) begin lat = t; break; end
    end
  endtask

  task automatic check_conv(input string name, input logic [31:0] cw);
    int lat;
    run_conv(cw, lat);
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL %s latency cw=%h got %0d want 33", name, cw, lat);
    end
    vectors++;
    if (output_bin !== model_bin(cw) || overflow !== (model_sum(cw) > 65535) ||
        non_canonical !== model_nc(cw)) begin
      miscompares++;
      $display("FAIL %s result cw=%h got bin=%h ovf=%b nc=%b want bin=%h ovf=%b nc=%b",
               name, cw, output_bin, overflow, non_canonical,
               model_bin(cw), model_sum(cw) > 65535, model_nc(cw));
    end
    @(negedge clk);
    vectors++;
    if (convert_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post_pulse done=%b busy=%b want 0 0", name, convert_done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({output_bin, overflow, non_canonical, busy, convert_done} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_state got bin=%h ovf=%b nc=%b busy=%b done=%b want all 0",
               output_bin, overflow, non_canonical, busy, convert_done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] tbl [9] = '{32'h0, 32'h1, 32'h15, 32'h0040_0000, 32'h3, 32'h4,
                             32'h0080_0000, 32'hFFFF_FFFF, 32'h0000_0010};
    for (int i = 0; i < 9; i++) check_conv("directed", tbl[i]);
    // Spot-check the model itself against known decode values.
    vectors++;
    if (model_bin(32'h0040_0000) !== 16'hB520 || model_sum(32'hFFFF_FFFF) != 64'd9227463) begin
      miscompares++;
      $display("FAIL model_anchor got %h %0d want b520 9227463",
               model_bin(32'h0040_0000), model_sum(32'hFFFF_FFFF));
    end
  endtask

  task automatic test_random();
    logic [31:0] cw;
    for (int i = 0; i < 24; i++) begin
      cw = $urandom;
      if (i % 3 != 0) cw = cw & ((32'h1 << $urandom_range(22, 4)) - 1);
      check_conv("random", cw);
    end
  endtask

  task automatic test_ignore_begin();
    int lat = -1;
    wait_idle();
    @(negedge clk);
    begin_f_b = 1'b1;
    input_fib = 32'h15;
    @(negedge clk);
    begin_f_b = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      if (t == 10) begin begin_f_b = 1'b1; input_fib = 32'hFFFF_FFFF; end
      if (t == 11) begin_f_b = 1'b0;
      @(negedge clk);
      if (convert_done) begin lat = t; break; end
    end
    vectors++;
    if (lat !== 33 || output_bin !== 16'd12 || overflow !== 1'b0 || non_canonical !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_begin got lat=%0d bin=%h ovf=%b nc=%b want 33 000c 0 0",
               lat, output_bin, overflow, non_canonical);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_begin_restart busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    wait_idle();
    @(negedge clk);
    begin_f_b = 1'b1;
    input_fib = 32'hFFFF_FFFF;
    @(negedge clk);
    begin_f_b = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({output_bin, overflow, non_canonical, busy, convert_done} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid got bin=%h ovf=%b nc=%b busy=%b done=%b want all 0",
               output_bin, overflow, non_canonical, busy, convert_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (convert_done) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_pulse got %0d pulses want 0", pulses);
    end
    check_conv("after_reset", 32'h15);
  endtask

  task automatic test_back_to_back();
    int times [$];
    logic [15:0] vals [$];
    wait_idle();
    @(negedge clk);
    begin_f_b = 1'b1;
    input_fib = 32'h10;
    @(negedge clk);
    for (int t = 1; t <= 105; t++) begin
      @(negedge clk);
      if (convert_done) begin times.push_back(t); vals.push_back(output_bin); end
    end
    begin_f_b = 1'b0;
    vectors++;
    if (times.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b_count got %0d pulses want 3", times.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (times[k] !== 33 + 34 * k || vals[k] !== 16'd8) begin
          miscompares++;
          $display("FAIL b2b_pulse%0d got edge=%0d bin=%h want edge=%0d bin=0008",
                   k, times[k], vals[k], 33 + 34 * k);
        end
      end
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    w[0] = 1;
    w[1] = 2;
    for (int i = 2; i < 32; i++) w[i] = w[i-1] + w[i-2];
    test_reset();
    test_directed();
    test_random();
    test_ignore_begin();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
